// File: rtl/inst_fetch_if.sv
// rtl/inst_fetch_if.sv - fetch-stage bus: instruction memory port, decode handshake, redirect
interface inst_fetch_if #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
);
  logic              memReq;
  logic [ADDR_W-1:0] memAddr;
  logic              memAck;
  logic [INST_W-1:0] memData;
  logic [INST_W-1:0] instToDecode;
  logic [ADDR_W-1:0] instPC;
  logic              instValid;
  logic              decodeReady;
  logic              redirectEn;
  logic [ADDR_W-1:0] redirectPC;

  modport master (
    output memReq, memAddr, instToDecode, instPC, instValid,
    input  memAck, memData, decodeReady, redirectEn, redirectPC
  );

  modport slave (
    input  memReq, memAddr, instToDecode, instPC, instValid,
    output memAck, memData, decodeReady, redirectEn, redirectPC
  );
endinterface

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - fetch stage: PC, single-outstanding memory read, instruction FIFO, redirect flush
module inst_fetch #(
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 32,
  parameter int                QDEPTH   = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic         clk,
  input logic         rst,
  inst_fetch_if.master bus
);
  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0]     QFULL = CW'(QDEPTH);
  localparam logic [INST_W-1:0] NOP   = INST_W'(32'h0000_0013);

  // IDLE: may issue; WAIT: request outstanding; DROP: request owed to memory but data unwanted
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DROP = 2'd2;

  logic [1:0]        state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] req_pc;
  logic [INST_W-1:0] q_inst [QDEPTH];
  logic [ADDR_W-1:0] q_pc   [QDEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [CW-1:0]     count;
  logic              valid;
  logic              push;
  logic              pop;

  assign valid = (count != '0);
  assign push  = (state == WAIT) && bus.memAck;
  assign pop   = valid && bus.decodeReady;

  assign bus.memReq       = (state != IDLE);
  assign bus.memAddr      = (state == IDLE) ? pc : req_pc;
  assign bus.instValid    = valid;
  assign bus.instToDecode = valid ? q_inst[rd_ptr] : NOP;
  assign bus.instPC       = valid ? q_pc[rd_ptr] : '0;

  // Control: reset, then redirect flush, then normal issue / complete / FIFO bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      pc     <= RESET_PC;
      req_pc <= RESET_PC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (bus.redirectEn) begin
      pc     <= bus.redirectPC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      if (state == WAIT)
        state <= bus.memAck ? IDLE : DROP;
      else if (state == DROP && bus.memAck)
        state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          // issue looks at registered count, so a same-cycle pop cannot free a slot
          if (count < QFULL) begin
            state  <= WAIT;
            req_pc <= pc;
            pc     <= pc + ADDR_W'(4);
          end
        end
        WAIT:    if (bus.memAck) state <= IDLE;
        DROP:    if (bus.memAck) state <= IDLE;
        default: state <= IDLE;
      endcase
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)
        count <= count + 1'b1;
      else if (pop && !push)
        count <= count - 1'b1;
    end
  end

  // FIFO storage write; never written on reset or redirect cycles
  always_ff @(posedge clk) begin
    if (!rst && !bus.redirectEn && push) begin
      q_inst[wr_ptr] <= bus.memData;
      q_pc[wr_ptr]   <= req_pc;
    end
  end
endmodule
